// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - serial line and received-byte signals of the 8N1 receiver
interface uart_rx_if;
  logic       rx_serial;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       rx_busy;

  modport master (
    input  rx_serial,
    output rx_data,
    output rx_valid,
    output frame_err,
    output rx_busy
  );

  modport slave (
    output rx_serial,
    input  rx_data,
    input  rx_valid,
    input  frame_err,
    input  rx_busy
  );
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver, mid-bit sampling, LSB-first byte assembly
module uart_rx #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       rst,
  uart_rx_if.master  rx
);
  localparam int          DIVISOR   = CLK_FREQ / BAUD_RATE;
  localparam int          HALF      = DIVISOR / 2;
  localparam logic [31:0] DIV_LAST  = 32'(DIVISOR - 1);
  localparam logic [31:0] HALF_LAST = 32'(HALF - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      state, state_d;
  logic [31:0] baud_cnt, baud_cnt_d;
  logic [2:0]  bit_index, bit_index_d;
  logic [7:0]  shifter, shifter_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        frame_err_q, frame_err_d;
  logic        sync1, rx_sync, rx_prev;

  // Synchroniser and edge-history flops reset to the idle-high line level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1   <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      sync1   <= rx.rx_serial;
      rx_sync <= sync1;
      rx_prev <= rx_sync;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      baud_cnt    <= '0;
      bit_index   <= '0;
      shifter     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state       <= state_d;
      baud_cnt    <= baud_cnt_d;
      bit_index   <= bit_index_d;
      shifter     <= shifter_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    state_d     = state;
    baud_cnt_d  = baud_cnt + 32'd1;
    bit_index_d = bit_index;
    shifter_d   = shifter;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    case (state)
      IDLE: begin
        baud_cnt_d = '0;
        // Only a fresh high-to-low edge arms the receiver; a held-low line does not.
        if (!rx_sync && rx_prev) state_d = START;
      end
      START: begin
        if (baud_cnt == HALF_LAST) begin
          baud_cnt_d  = '0;
          bit_index_d = '0;
          state_d     = rx_sync ? IDLE : DATA;
        end
      end
      DATA: begin
        if (baud_cnt == DIV_LAST) begin
          baud_cnt_d = '0;
          shifter_d  = {rx_sync, shifter[7:1]};
          if (bit_index == 3'd7) state_d = STOP;
          else                   bit_index_d = bit_index + 3'd1;
        end
      end
      STOP: begin
        // Return to IDLE at mid-stop-bit so a back-to-back start edge is not missed.
        if (baud_cnt == DIV_LAST) begin
          baud_cnt_d = '0;
          state_d    = IDLE;
          if (rx_sync) begin
            rx_data_d  = shifter;
            rx_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rx.rx_data   = rx_data_q;
  assign rx.rx_valid  = rx_valid_q;
  assign rx.frame_err = frame_err_q;
  assign rx.rx_busy   = (state != IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed bench for uart_rx at 10 clocks per bit
module tb_uart_rx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  uart_rx_if bus ();

  uart_rx #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000)) dut (
    .clk (clk),
    .rst (rst),
    .rx  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_valid;
    int         exp_err;
    logic [7:0] exp_data;
  } vec_t;

  vec_t       vecs [6];
  int         cyc = 0;
  int         valid_cnt = 0, err_cnt = 0, both_cnt = 0;
  int         valid_cyc = 0;
  logic       busy_at_valid = 1'b1;
  logic [7:0] rxq [$];
  int         checks = 0, passed = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.rx_valid) begin
      valid_cnt++;
      valid_cyc     = cyc;
      busy_at_valid = bus.rx_busy;
      rxq.push_back(bus.rx_data);
    end
    if (bus.frame_err) err_cnt++;
    if (bus.rx_valid && bus.frame_err) both_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive_bit(input logic b);
    bus.rx_serial = b;
    repeat (10) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop);
  endtask

  task automatic idle(input int n);
    bus.rx_serial = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int   v0, e0, t0;
    logic saw_busy;

    vecs[0] = '{8'hA5, 1'b1, 1, 0, 8'hA5};
    vecs[1] = '{8'h11, 1'b1, 1, 0, 8'h11};
    vecs[2] = '{8'h5A, 1'b0, 0, 1, 8'h11};
    vecs[3] = '{8'h00, 1'b1, 1, 0, 8'h00};
    vecs[4] = '{8'hFF, 1'b1, 1, 0, 8'hFF};
    vecs[5] = '{8'h3C, 1'b1, 1, 0, 8'h3C};

    bus.rx_serial = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_rx_data", 32'(bus.rx_data), 32'h00);
    check("reset_rx_valid", 32'(bus.rx_valid), 32'h0);
    check("reset_frame_err", 32'(bus.frame_err), 32'h0);
    check("reset_rx_busy", 32'(bus.rx_busy), 32'h0);
    rst = 1'b0;
    idle(5);

    // Latency: pulse lands in the cycle after edge E0+2+HALF+9*DIVISOR = E0+97.
    v0 = valid_cnt; e0 = err_cnt; t0 = cyc;
    send_frame(8'hA5, 1'b1);
    idle(5);
    check("lat_valid_count", 32'(valid_cnt - v0), 32'd1);
    check("lat_cycle", 32'(valid_cyc - t0), 32'd98);
    check("lat_busy_fall", 32'(busy_at_valid), 32'h0);
    check("lat_data", 32'(bus.rx_data), 32'hA5);
    check("lat_err", 32'(err_cnt - e0), 32'd0);

    for (int i = 0; i < 6; i++) begin
      v0 = valid_cnt; e0 = err_cnt;
      send_frame(vecs[i].data, vecs[i].stop);
      idle(5);
      check($sformatf("vec%0d_valid", i), 32'(valid_cnt - v0), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d_err", i), 32'(err_cnt - e0), 32'(vecs[i].exp_err));
      check($sformatf("vec%0d_data", i), 32'(bus.rx_data), 32'(vecs[i].exp_data));
    end

    rxq.delete();
    v0 = valid_cnt; e0 = err_cnt;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h3C, 1'b1);
    idle(10);
    check("b2b_count", 32'(valid_cnt - v0), 32'd3);
    check("b2b_err", 32'(err_cnt - e0), 32'd0);
    check("b2b_q0", (rxq.size() > 0) ? 32'(rxq[0]) : 32'hDEAD, 32'h00);
    check("b2b_q1", (rxq.size() > 1) ? 32'(rxq[1]) : 32'hDEAD, 32'hFF);
    check("b2b_q2", (rxq.size() > 2) ? 32'(rxq[2]) : 32'hDEAD, 32'h3C);

    v0 = valid_cnt; e0 = err_cnt; saw_busy = 1'b0;
    bus.rx_serial = 1'b0;
    repeat (3) @(negedge clk);
    bus.rx_serial = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (bus.rx_busy) saw_busy = 1'b1;
    end
    check("glitch_saw_busy", 32'(saw_busy), 32'h1);
    check("glitch_busy_clear", 32'(bus.rx_busy), 32'h0);
    idle(20);
    check("glitch_no_valid", 32'(valid_cnt - v0), 32'd0);
    check("glitch_no_err", 32'(err_cnt - e0), 32'd0);

    v0 = valid_cnt; e0 = err_cnt;
    bus.rx_serial = 1'b0;
    repeat (400) @(negedge clk);
    check("break_err", 32'(err_cnt - e0), 32'd1);
    check("break_no_valid", 32'(valid_cnt - v0), 32'd0);
    idle(20);
    check("break_no_extra", 32'(err_cnt - e0), 32'd1);
    v0 = valid_cnt;
    send_frame(8'h77, 1'b1);
    idle(5);
    check("after_break_valid", 32'(valid_cnt - v0), 32'd1);
    check("after_break_data", 32'(bus.rx_data), 32'h77);

    // Assert reset halfway through data bit 4 of 8'hC3.
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'(8'hC3 >> i));
    bus.rx_serial = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_mid_data", 32'(bus.rx_data), 32'h00);
    check("rst_mid_busy", 32'(bus.rx_busy), 32'h0);
    check("rst_mid_valid", 32'(bus.rx_valid), 32'h0);
    check("rst_mid_err", 32'(bus.frame_err), 32'h0);
    bus.rx_serial = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    v0 = valid_cnt; e0 = err_cnt;
    idle(20);
    check("post_rst_quiet", 32'(valid_cnt - v0), 32'd0);
    send_frame(8'h42, 1'b1);
    idle(5);
    check("post_rst_valid", 32'(valid_cnt - v0), 32'd1);
    check("post_rst_err", 32'(err_cnt - e0), 32'd0);
    check("post_rst_data", 32'(bus.rx_data), 32'h42);

    check("never_both", 32'(both_cnt), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
